// File: rtl/rv32f_mem_stage.sv
// rv32f_mem_stage -- memory/writeback stage behind the RV32F FP execute unit.
//
// Takes one operation per iVALID/oREADY handshake: flw (RAM read), fsw
// (RAM write) or a pass-through FP result. Loads and pass-through results are
// presented to the FP register file on a valid/ready writeback port. Only one
// operation is in flight at a time; oREADY is high only in IDLE.
//
// Ports
//   iCLK, iRST_N          clock, asynchronous active-low reset
//   iVALID / oREADY       execute-side handshake
//   iIS_LOAD, iIS_STORE   op decode (load wins if both high)
//   iRD, iADDR, iWDATA    destination reg, RAM word address, store data
//   iALU_RESULT           pass-through result
//   oRAM_CE/RD/WR         registered RAM strobes
//   oRAM_ADDR, oRAM_DATA  registered RAM address / store data (0 unless storing)
//   iRAM_DATA, iRAM_ACK   RAM read data and completion
//   oWB_VALID/RD/DATA     writeback port, iWB_READY accepts it
//   oERR                  one-cycle pulse on a timed-out RAM access
//
// Build option
//   RV32F_MEM_TIMEOUT_EN  when defined, a RAM access with no ack for TIMEOUT
//                         WAIT edges is aborted and oERR pulses. When
//                         undefined, WAIT lasts until ack and oERR is 0.

module rv32f_mem_stage #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iVALID,
   output logic              oREADY,
   input  logic              iIS_LOAD,
   input  logic              iIS_STORE,
   input  logic [4:0]        iRD,
   input  logic [ADDR_W-1:0] iADDR,
   input  logic [31:0]       iWDATA,
   input  logic [31:0]       iALU_RESULT,
   output logic              oRAM_CE,
   output logic              oRAM_RD,
   output logic              oRAM_WR,
   output logic [ADDR_W-1:0] oRAM_ADDR,
   output logic [31:0]       oRAM_DATA,
   input  logic [31:0]       iRAM_DATA,
   input  logic              iRAM_ACK,
   output logic              oWB_VALID,
   output logic [4:0]        oWB_RD,
   output logic [31:0]       oWB_DATA,
   input  logic              iWB_READY,
   output logic              oERR
);

   // Elaboration-time range check on the timeout length.
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : gTimeoutRange
      $error("rv32f_mem_stage: TIMEOUT must be in 1..255");
   end

   typedef enum logic [1:0] {IDLE, WAIT, WB_HOLD} state_t;

   state_t            state, nState;
   logic              ramCe, ramRd, ramWr;
   logic              nRamCe, nRamRd, nRamWr;
   logic [ADDR_W-1:0] ramAddr, nRamAddr;
   logic [31:0]       ramData, nRamData;
   logic              wbValid, nWbValid;
   logic [4:0]        wbRd, nWbRd;
   logic [31:0]       wbData, nWbData;

`ifdef RV32F_MEM_TIMEOUT_EN
   logic [7:0]        cnt, nCnt;
   logic              err, nErr;
`endif

   // Next-state and next-output decode.
   always_comb begin
      nState   = state;
      nRamCe   = ramCe;
      nRamRd   = ramRd;
      nRamWr   = ramWr;
      nRamAddr = ramAddr;
      nRamData = ramData;
      nWbValid = wbValid;
      nWbRd    = wbRd;
      nWbData  = wbData;
`ifdef RV32F_MEM_TIMEOUT_EN
      nCnt     = cnt;
      nErr     = 1'b0;      // pulse: only ever high for the abort cycle
`endif
      case (state)
         IDLE: begin
            if (iVALID) begin
               nWbRd    = iRD;
               nRamAddr = iADDR;
               if (iIS_LOAD) begin
                  nRamCe   = 1'b1;
                  nRamRd   = 1'b1;
                  nRamWr   = 1'b0;
                  nRamData = '0;
`ifdef RV32F_MEM_TIMEOUT_EN
                  nCnt     = '0;
`endif
                  nState   = WAIT;
               end else if (iIS_STORE) begin
                  nRamCe   = 1'b1;
                  nRamRd   = 1'b0;
                  nRamWr   = 1'b1;
                  nRamData = iWDATA;
`ifdef RV32F_MEM_TIMEOUT_EN
                  nCnt     = '0;
`endif
                  nState   = WAIT;
               end else begin
                  nWbData  = iALU_RESULT;
                  nWbValid = 1'b1;
                  nState   = WB_HOLD;
               end
            end
         end
         WAIT: begin
            if (iRAM_ACK) begin
               // Ack takes priority over a timeout expiring on the same edge.
               nRamCe   = 1'b0;
               nRamRd   = 1'b0;
               nRamWr   = 1'b0;
               nRamData = '0;
               if (ramRd) begin
                  nWbData  = iRAM_DATA;
                  nWbValid = 1'b1;
                  nState   = WB_HOLD;
               end else begin
                  nState   = IDLE;
               end
            end
`ifdef RV32F_MEM_TIMEOUT_EN
            else if (cnt == 8'(TIMEOUT - 1)) begin
               // TIMEOUT-th edge without ack: abort, no writeback.
               nRamCe   = 1'b0;
               nRamRd   = 1'b0;
               nRamWr   = 1'b0;
               nRamData = '0;
               nErr     = 1'b1;
               nState   = IDLE;
            end else begin
               nCnt     = cnt + 8'd1;
            end
`endif
         end
         WB_HOLD: begin
            if (iWB_READY) begin
               nWbValid = 1'b0;
               nState   = IDLE;
            end
         end
         default: nState = IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state   <= IDLE;
         ramCe   <= 1'b0;
         ramRd   <= 1'b0;
         ramWr   <= 1'b0;
         ramAddr <= '0;
         ramData <= '0;
         wbValid <= 1'b0;
         wbRd    <= '0;
         wbData  <= '0;
      end else begin
         state   <= nState;
         ramCe   <= nRamCe;
         ramRd   <= nRamRd;
         ramWr   <= nRamWr;
         ramAddr <= nRamAddr;
         ramData <= nRamData;
         wbValid <= nWbValid;
         wbRd    <= nWbRd;
         wbData  <= nWbData;
      end
   end

`ifdef RV32F_MEM_TIMEOUT_EN
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         cnt <= nCnt;
         err <= nErr;
      end
   end
   assign oERR = err;
`else
   assign oERR = 1'b0;
`endif

   assign oREADY    = (state == IDLE);
   assign oRAM_CE   = ramCe;
   assign oRAM_RD   = ramRd;
   assign oRAM_WR   = ramWr;
   assign oRAM_ADDR = ramAddr;
   assign oRAM_DATA = ramData;
   assign oWB_VALID = wbValid;
   assign oWB_RD    = wbRd;
   assign oWB_DATA  = wbData;

endmodule

// File: tb/tb_rv32f_mem_stage.sv
// Directed testbench for rv32f_mem_stage. Inputs are driven and outputs
// sampled on the falling edge; the DUT acts on the rising edge.

module tb_rv32f_mem_stage;

   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 4;

   logic              iCLK, iRST_N;
   logic              iVALID, oREADY, iIS_LOAD, iIS_STORE;
   logic [4:0]        iRD;
   logic [ADDR_W-1:0] iADDR;
   logic [31:0]       iWDATA, iALU_RESULT;
   logic              oRAM_CE, oRAM_RD, oRAM_WR;
   logic [ADDR_W-1:0] oRAM_ADDR;
   logic [31:0]       oRAM_DATA, iRAM_DATA;
   logic              iRAM_ACK;
   logic              oWB_VALID;
   logic [4:0]        oWB_RD;
   logic [31:0]       oWB_DATA;
   logic              iWB_READY, oERR;

   int nChecks = 0;
   int nErrors = 0;

   rv32f_mem_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N),
      .iVALID(iVALID), .oREADY(oREADY),
      .iIS_LOAD(iIS_LOAD), .iIS_STORE(iIS_STORE),
      .iRD(iRD), .iADDR(iADDR), .iWDATA(iWDATA), .iALU_RESULT(iALU_RESULT),
      .oRAM_CE(oRAM_CE), .oRAM_RD(oRAM_RD), .oRAM_WR(oRAM_WR),
      .oRAM_ADDR(oRAM_ADDR), .oRAM_DATA(oRAM_DATA),
      .iRAM_DATA(iRAM_DATA), .iRAM_ACK(iRAM_ACK),
      .oWB_VALID(oWB_VALID), .oWB_RD(oWB_RD), .oWB_DATA(oWB_DATA),
      .iWB_READY(iWB_READY), .oERR(oERR)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   // Issue one operation; it is accepted at the next rising edge.
   task automatic issue(input logic ld, input logic st, input logic [4:0] rd,
                        input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                        input logic [31:0] alu);
      iVALID = 1'b1; iIS_LOAD = ld; iIS_STORE = st; iRD = rd;
      iADDR = a; iWDATA = wd; iALU_RESULT = alu;
      @(negedge iCLK);
      iVALID = 1'b0; iIS_LOAD = 1'b0; iIS_STORE = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      nChecks++;
      if ({oRAM_CE, oRAM_RD, oRAM_WR, oWB_VALID, oERR} !== 5'b0 ||
          oRAM_ADDR !== '0 || oRAM_DATA !== 32'h0 || oWB_RD !== 5'h0 ||
          oWB_DATA !== 32'h0) begin
         nErrors++;
         $display("FAIL reset_outputs: ce/rd/wr/wbv/err=%b%b%b%b%b addr=%h rdata=%h wbrd=%h wbdata=%h, need all 0",
                  oRAM_CE, oRAM_RD, oRAM_WR, oWB_VALID, oERR, oRAM_ADDR, oRAM_DATA, oWB_RD, oWB_DATA);
      end
      nChecks++;
      if (oREADY !== 1'b1) begin
         nErrors++; $display("FAIL reset_ready: got %b need 1", oREADY);
      end
      @(negedge iCLK);
      iRST_N = 1'b1;
      @(negedge iCLK);
   endtask

   task automatic test_passthru;
      iWB_READY = 1'b1;
      issue(1'b0, 1'b0, 5'd5, 8'h00, 32'h0, 32'h3F800000);
      nChecks++;
      if (oWB_VALID !== 1'b1 || oWB_RD !== 5'd5 || oWB_DATA !== 32'h3F800000) begin
         nErrors++;
         $display("FAIL passthru_wb: v=%b rd=%0d data=%h need 1/5/3f800000", oWB_VALID, oWB_RD, oWB_DATA);
      end
      nChecks++;
      if ({oRAM_CE, oRAM_RD, oRAM_WR, oREADY} !== 4'b0000) begin
         nErrors++;
         $display("FAIL passthru_strobes: ce/rd/wr/ready=%b%b%b%b need 0000", oRAM_CE, oRAM_RD, oRAM_WR, oREADY);
      end
      @(negedge iCLK);
      nChecks++;
      if (oWB_VALID !== 1'b0 || oREADY !== 1'b1) begin
         nErrors++; $display("FAIL passthru_done: v=%b ready=%b need 0/1", oWB_VALID, oREADY);
      end
   endtask

   task automatic test_load;
      logic bad;
      bad = 1'b0;
      iWB_READY = 1'b1;
      iRAM_ACK  = 1'b0;
      issue(1'b1, 1'b0, 5'd3, 8'h10, 32'h0, 32'h0);
      // Strobes visible for three sample points, ack on the third.
      for (int k = 0; k < 3; k++) begin
         if ({oRAM_CE, oRAM_RD, oRAM_WR} !== 3'b110 || oRAM_ADDR !== 8'h10 ||
             oREADY !== 1'b0 || oWB_VALID !== 1'b0) bad = 1'b1;
         if (k == 2) begin iRAM_ACK = 1'b1; iRAM_DATA = 32'h40490FDB; end
         @(negedge iCLK);
      end
      iRAM_ACK = 1'b0; iRAM_DATA = 32'h0;
      nChecks++;
      if (bad) begin
         nErrors++; $display("FAIL load_strobes: strobes/addr not 110/0x10 for 3 cycles");
      end
      nChecks++;
      if (oWB_VALID !== 1'b1 || oWB_RD !== 5'd3 || oWB_DATA !== 32'h40490FDB ||
          {oRAM_CE, oRAM_RD} !== 2'b00) begin
         nErrors++;
         $display("FAIL load_wb: v=%b rd=%0d data=%h ce/rd=%b%b need 1/3/40490fdb/00",
                  oWB_VALID, oWB_RD, oWB_DATA, oRAM_CE, oRAM_RD);
      end
      @(negedge iCLK);
      nChecks++;
      if (oWB_VALID !== 1'b0 || oREADY !== 1'b1) begin
         nErrors++; $display("FAIL load_done: v=%b ready=%b need 0/1", oWB_VALID, oREADY);
      end
   endtask

   task automatic test_store_backpressure;
      logic bad;
      bad = 1'b0;
      iRAM_ACK = 1'b0;
      issue(1'b0, 1'b1, 5'd7, 8'h20, 32'hC0000000, 32'h0);
      nChecks++;
      if ({oRAM_CE, oRAM_RD, oRAM_WR} !== 3'b101 || oRAM_ADDR !== 8'h20 ||
          oRAM_DATA !== 32'hC0000000) begin
         nErrors++;
         $display("FAIL store_strobes: ce/rd/wr=%b%b%b addr=%h data=%h need 101/20/c0000000",
                  oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA);
      end
      iRAM_ACK = 1'b1;
      @(negedge iCLK);
      iRAM_ACK = 1'b0;
      nChecks++;
      if ({oRAM_CE, oRAM_WR, oWB_VALID} !== 3'b000 || oRAM_DATA !== 32'h0 || oREADY !== 1'b1) begin
         nErrors++;
         $display("FAIL store_done: ce/wr/wbv=%b%b%b data=%h ready=%b need 000/0/1",
                  oRAM_CE, oRAM_WR, oWB_VALID, oRAM_DATA, oREADY);
      end
      // Pass-through held by backpressure; the input changes must not leak.
      iWB_READY = 1'b0;
      issue(1'b0, 1'b0, 5'd9, 8'h00, 32'h0, 32'h12345678);
      for (int k = 0; k < 4; k++) begin
         iALU_RESULT = 32'hDEAD0000 + k;
         iVALID = 1'b1;
         if (oWB_VALID !== 1'b1 || oWB_DATA !== 32'h12345678 || oWB_RD !== 5'd9 ||
             oREADY !== 1'b0) bad = 1'b1;
         @(negedge iCLK);
      end
      iVALID = 1'b0;
      nChecks++;
      if (bad) begin
         nErrors++; $display("FAIL backpressure_hold: wb not stable 1/9/12345678 for 4 cycles");
      end
      iWB_READY = 1'b1;
      @(negedge iCLK);
      nChecks++;
      if (oWB_VALID !== 1'b0 || oREADY !== 1'b1) begin
         nErrors++; $display("FAIL backpressure_release: v=%b ready=%b need 0/1", oWB_VALID, oREADY);
      end
   endtask

   task automatic test_reset_mid_load;
      iRAM_ACK = 1'b0;
      issue(1'b1, 1'b0, 5'd4, 8'h33, 32'h0, 32'h0);
      nChecks++;
      if ({oRAM_CE, oRAM_RD} !== 2'b11) begin
         nErrors++; $display("FAIL rstmid_pre: ce/rd=%b%b need 11", oRAM_CE, oRAM_RD);
      end
      #2 iRST_N = 1'b0;
      #1;
      nChecks++;
      if ({oRAM_CE, oRAM_RD, oRAM_WR, oWB_VALID, oERR} !== 5'b0 || oREADY !== 1'b1 ||
          oRAM_ADDR !== '0) begin
         nErrors++;
         $display("FAIL rstmid_async: ce/rd/wr/wbv/err=%b%b%b%b%b ready=%b addr=%h need 00000/1/0",
                  oRAM_CE, oRAM_RD, oRAM_WR, oWB_VALID, oERR, oREADY, oRAM_ADDR);
      end
      @(negedge iCLK);
      iRST_N = 1'b1;
      iRAM_ACK = 1'b1; iRAM_DATA = 32'hBADBAD00;
      @(negedge iCLK);
      @(negedge iCLK);
      nChecks++;
      if (oWB_VALID !== 1'b0 || oRAM_CE !== 1'b0 || oREADY !== 1'b1) begin
         nErrors++;
         $display("FAIL rstmid_late_ack: wbv=%b ce=%b ready=%b need 0/0/1", oWB_VALID, oRAM_CE, oREADY);
      end
      iRAM_ACK = 1'b0; iRAM_DATA = 32'h0;
   endtask

`ifdef RV32F_MEM_TIMEOUT_EN
   task automatic test_timeout;
      logic bad;
      bad = 1'b0;
      iRAM_ACK = 1'b0;
      iWB_READY = 1'b1;
      issue(1'b1, 1'b0, 5'd6, 8'h44, 32'h0, 32'h0);
      for (int k = 0; k < TIMEOUT; k++) begin
         if ({oRAM_CE, oRAM_RD} !== 2'b11 || oERR !== 1'b0) bad = 1'b1;
         @(negedge iCLK);
      end
      nChecks++;
      if (bad) begin
         nErrors++; $display("FAIL timeout_wait: strobes not held / early oERR during WAIT");
      end
      nChecks++;
      if ({oRAM_CE, oRAM_RD, oWB_VALID} !== 3'b000 || oERR !== 1'b1 || oREADY !== 1'b1) begin
         nErrors++;
         $display("FAIL timeout_abort: ce/rd/wbv=%b%b%b err=%b ready=%b need 000/1/1",
                  oRAM_CE, oRAM_RD, oWB_VALID, oERR, oREADY);
      end
      @(negedge iCLK);
      nChecks++;
      if (oERR !== 1'b0 || oWB_VALID !== 1'b0) begin
         nErrors++; $display("FAIL timeout_pulse: err=%b wbv=%b need 0/0", oERR, oWB_VALID);
      end
      // Ack on the expiring edge wins.
      issue(1'b1, 1'b0, 5'd6, 8'h44, 32'h0, 32'h0);
      for (int k = 0; k < TIMEOUT; k++) begin
         if (k == TIMEOUT - 1) begin iRAM_ACK = 1'b1; iRAM_DATA = 32'h0BADF00D; end
         @(negedge iCLK);
      end
      iRAM_ACK = 1'b0;
      nChecks++;
      if (oWB_VALID !== 1'b1 || oWB_DATA !== 32'h0BADF00D || oERR !== 1'b0) begin
         nErrors++;
         $display("FAIL timeout_ack_wins: wbv=%b data=%h err=%b need 1/0badf00d/0", oWB_VALID, oWB_DATA, oERR);
      end
      @(negedge iCLK);
   endtask
`else
   task automatic test_no_timeout;
      logic bad;
      bad = 1'b0;
      iRAM_ACK = 1'b0;
      iWB_READY = 1'b1;
      issue(1'b1, 1'b0, 5'd8, 8'h55, 32'h0, 32'h0);
      for (int k = 0; k < 100; k++) begin
         if ({oRAM_CE, oRAM_RD} !== 2'b11 || oERR !== 1'b0 || oWB_VALID !== 1'b0) bad = 1'b1;
         if (k == 99) begin iRAM_ACK = 1'b1; iRAM_DATA = 32'hC2C80000; end
         @(negedge iCLK);
      end
      iRAM_ACK = 1'b0;
      nChecks++;
      if (bad) begin
         nErrors++; $display("FAIL notimeout_hold: strobes dropped or oERR during 100-cycle WAIT");
      end
      nChecks++;
      if (oWB_VALID !== 1'b1 || oWB_RD !== 5'd8 || oWB_DATA !== 32'hC2C80000 || oERR !== 1'b0) begin
         nErrors++;
         $display("FAIL notimeout_wb: v=%b rd=%0d data=%h err=%b need 1/8/c2c80000/0",
                  oWB_VALID, oWB_RD, oWB_DATA, oERR);
      end
      @(negedge iCLK);
   endtask
`endif

   initial begin
      iRST_N = 1'b0; iVALID = 1'b0; iIS_LOAD = 1'b0; iIS_STORE = 1'b0;
      iRD = '0; iADDR = '0; iWDATA = '0; iALU_RESULT = '0;
      iRAM_DATA = '0; iRAM_ACK = 1'b0; iWB_READY = 1'b0;
      test_reset;
      test_passthru;
      test_load;
      test_store_backpressure;
      test_reset_mid_load;
`ifdef RV32F_MEM_TIMEOUT_EN
      test_timeout;
`else
      test_no_timeout;
`endif
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
